// File: rtl/mm_seq_detector.sv
// Overlapping Mealy detector for the serial pattern 101011 (first bit first).
// The detect flag is combinational and flags the cycle holding the final pattern bit.
module mm_seq_detector (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;

    logic [2:0] state_q;
    logic [2:0] state_d;

    // NOTE: defaulting state_d before the case keeps this block free of latches.
    always_comb begin
        state_d = S0;
        unique case (state_q)
            S0:      state_d = in ? S1 : S0;
            S1:      state_d = in ? S1 : S2;
            S2:      state_d = in ? S3 : S0;
            S3:      state_d = in ? S1 : S4;
            S4:      state_d = in ? S5 : S0;
            S5:      state_d = in ? S1 : S4;
            default: state_d = S0;
        endcase
    end

    // NOTE: state uses non-blocking assignment so every flop updates from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Gating with reset holds the flag low for the whole time reset is asserted.
    always_comb begin
        out = reset && (state_q == S5) && in;
    end

endmodule

// File: tb/tb_mm_seq_detector.sv
// Directed bench for mm_seq_detector: a vector table plus hand-written
// sequences for asynchronous reset and between-edge input changes.
module tb_mm_seq_detector;

    logic clk;
    logic reset;
    logic in;
    logic out;

    int checks;
    int failures;

    typedef struct {
        logic  rst_v;
        logic  in_v;
        logic  exp_out;
        string name;
    } vec_t;

    vec_t vecs[$];

    mm_seq_detector dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: out=%b expected=%b at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic add(input logic r, input logic b, input logic e, input string n);
        vec_t v;
        v.rst_v   = r;
        v.in_v    = b;
        v.exp_out = e;
        v.name    = n;
        vecs.push_back(v);
    endtask

    task automatic add_bits(input string n, input logic [15:0] bits, input logic [15:0] exp,
                            input int len);
        for (int i = len - 1; i >= 0; i--) begin
            add(1'b1, bits[i], exp[i], $sformatf("%s_bit%0d", n, len - i));
        end
    endtask

    // Drive one bit after the falling edge and check the Mealy output mid-cycle.
    task automatic drive(input logic r, input logic b, input logic e, input string n);
        @(negedge clk);
        reset = r;
        in    = b;
        #1;
        check(n, out, e);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        in       = 1'b0;

        // Reset held for several cycles with in toggling: out stays low even with in=1.
        add(1'b0, 1'b1, 1'b0, "reset_in1_a");
        add(1'b0, 1'b0, 1'b0, "reset_in0_a");
        add(1'b0, 1'b1, 1'b0, "reset_in1_b");
        add(1'b0, 1'b1, 1'b0, "reset_in1_c");
        // Basic match, then overlap: trailing 1 starts the next match.
        add_bits("basic",   16'b101011, 16'b000001, 6);
        add_bits("overlap", 16'b01011,  16'b00001,  5);
        // Reset, then a match that passes through the S5 -> S4 return.
        add(1'b0, 1'b0, 1'b0, "reset_between");
        add_bits("s5_ret", 16'b10101011, 16'b00000001, 8);
        // Long runs of 0s and 1s never detect.
        for (int i = 0; i < 12; i++) add(1'b1, 1'b0, 1'b0, $sformatf("zeros_%0d", i));
        begin
            logic [5:0] pat;
            pat = 6'b101011;
            for (int k = 5; k >= 0; k--) begin
                for (int j = 0; j < 5; j++) begin
                    add(1'b1, pat[k], 1'b0, $sformatf("stretch_b%0d_%0d", 6 - k, j));
                end
            end
        end

        foreach (vecs[i]) begin
            drive(vecs[i].rst_v, vecs[i].in_v, vecs[i].exp_out, vecs[i].name);
        end

        // Mid-sequence asynchronous reset: reach S5 with 1,0,1,0,1.
        drive(1'b0, 1'b0, 1'b0, "mid_pre_reset");
        drive(1'b1, 1'b1, 1'b0, "mid_b1");
        drive(1'b1, 1'b0, 1'b0, "mid_b2");
        drive(1'b1, 1'b1, 1'b0, "mid_b3");
        drive(1'b1, 1'b0, 1'b0, "mid_b4");
        drive(1'b1, 1'b1, 1'b0, "mid_b5");
        // In S5: out follows in between edges without waiting for a clock.
        @(negedge clk);
        in = 1'b1;
        #1 check("between_edge_in1", out, 1'b1);
        in = 1'b0;
        #1 check("between_edge_in0", out, 1'b0);
        in = 1'b1;
        #1 check("between_edge_in1_again", out, 1'b1);
        // Reset pulse between edges clears history immediately.
        reset = 1'b0;
        #0.5 check("async_reset_gates_out", out, 1'b0);
        #0.5 reset = 1'b1;
        #0.5 check("after_async_reset_s0", out, 1'b0);
        // The first edge after release samples in=1 from S0; no stale detect.
        drive(1'b1, 1'b1, 1'b0, "post_reset_1");
        // Fresh 101011 after the reset.
        drive(1'b1, 1'b1, 1'b0, "fresh_b1");
        drive(1'b1, 1'b0, 1'b0, "fresh_b2");
        drive(1'b1, 1'b1, 1'b0, "fresh_b3");
        drive(1'b1, 1'b0, 1'b0, "fresh_b4");
        drive(1'b1, 1'b1, 1'b0, "fresh_b5");
        drive(1'b1, 1'b1, 1'b1, "fresh_b6");
        // Single-cycle pulse: the next cycle with in=1 no longer detects.
        drive(1'b1, 1'b1, 1'b0, "pulse_ends");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mm_seq_detector.md
MM_SEQ_DETECTOR -- requirements
Module: mm_seq_detector

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-002 The clk port SHALL be a 1-bit input: rising-edge clock for all state.
REQ-003 The reset port SHALL be a 1-bit input: active-low asynchronous reset (0 = reset asserted).
REQ-004 The in port SHALL be a 1-bit input: serial data bit, sampled on each rising clk edge.
REQ-005 The out port SHALL be a 1-bit output: Mealy detect flag, 1 for the cycle in which the final bit of 101011 is present on in.
REQ-006 The block SHALL have no parameters; the pattern 101011 (first-received bit first) SHALL be fixed.

Function
REQ-007 The block SHALL be a Mealy FSM with six states: S0 idle, S1 "1", S2 "10", S3 "101", S4 "1010", S5 "10101".
REQ-008 States SHALL use 3-bit binary encoding S0=0 through S5=5.
REQ-009 Unused codes 6 and 7 SHALL return to S0 on the next edge with out=0.
REQ-010 Transitions from S0 SHALL be: in=1 -> S1; in=0 -> S0.
REQ-011 Transitions from S1 SHALL be: in=0 -> S2; in=1 -> S1.
REQ-012 Transitions from S2 SHALL be: in=1 -> S3; in=0 -> S0.
REQ-013 Transitions from S3 SHALL be: in=0 -> S4; in=1 -> S1.
REQ-014 Transitions from S4 SHALL be: in=1 -> S5; in=0 -> S0.
REQ-015 Transitions from S5 SHALL be: in=1 -> S1 with detect; in=0 -> S4.
REQ-016 out SHALL be combinational: out = (state==S5) AND (in==1) AND reset deasserted.
REQ-017 out SHALL have zero-cycle latency: it is valid in the same cycle as the sixth pattern bit, before the capturing edge.
REQ-018 out SHALL be a single-cycle pulse per detection.
REQ-019 Detection SHALL be overlapping: the trailing 1 of a match SHALL count as the leading 1 of the next match.
REQ-020 Any number of consecutive 0s or 1s outside the pattern SHALL NOT produce a detect.
REQ-021 A change on in between clock edges SHALL affect out immediately but SHALL affect state only at the next rising edge.

Reset
REQ-022 While reset=0, state SHALL be forced to S0 immediately, regardless of clk, and out SHALL be 0 regardless of in.
REQ-023 After reset deasserts, the first rising edge SHALL sample in from S0.
REQ-024 Reset asserted mid-sequence SHALL discard all partial-match history.
REQ-025 The reset value of out SHALL be 0.

Verification
REQ-026 Bench SHALL cover reset: hold reset=0 for 2 cycles with in toggling -> out=0 throughout; state=S0 on release.
REQ-027 Bench SHALL cover a basic match: after reset, drive 1,0,1,0,1,1 one bit per cycle -> out=1 only during the 6th bit cycle, 0 on bits 1-5.
REQ-028 Bench SHALL cover overlap: drive 1,0,1,0,1,1,0,1,0,1,1 -> out=1 during bit 6 and bit 11 only.
REQ-029 Bench SHALL cover the S5 0-return: drive 1,0,1,0,1,0,1,1 -> out=1 during bit 8 only.
REQ-030 Bench SHALL cover no match: drive 12 consecutive 0s, then the 101011 levels each held for 5 cycles -> out=0 throughout.
REQ-031 Bench SHALL cover reset mid-sequence: drive 1,0,1,0,1, pulse reset=0 asynchronously between edges, release, drive 1 -> out=0; a fresh 101011 afterwards -> out=1 on its 6th bit.
